// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch/decode boundary of the RV32I core.
package fetch_queue_pkg;

  localparam int WORD_W   = 32;
  localparam int FQ_DEPTH = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    word_t PC;
    word_t Instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch, the prefetch queue and decode.
interface fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) ();

  localparam int CW = $clog2(DEPTH) + 1;

  logic            Flush;
  logic            PushValid;
  logic            PushReady;
  logic [XLEN-1:0] PushPC;
  logic [XLEN-1:0] PushInstr;
  logic            PopValid;
  logic            PopReady;
  logic [XLEN-1:0] PopPC;
  logic [XLEN-1:0] PopInstr;
  logic [XLEN-1:0] PopPCPlus4;
  logic [CW-1:0]   Count;

  // Core side: fetch pushes, decode pops, PCSrc redirect flushes.
  modport master (
    output Flush, PushValid, PushPC, PushInstr, PopReady,
    input  PushReady, PopValid, PopPC, PopInstr, PopPCPlus4, Count
  );

  // Queue side.
  modport slave (
    input  Flush, PushValid, PushPC, PushInstr, PopReady,
    output PushReady, PopValid, PopPC, PopInstr, PopPCPlus4, Count
  );

endinterface

// File: rtl/fetch_queue.sv
// Flushable circular prefetch queue of {PC, instruction} entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int XLEN  = WORD_W,
  parameter int DEPTH = FQ_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  fetch_queue_if.slave   fq
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push  = fq.PushValid & ~full;
  assign pop   = fq.PopReady & ~empty;

  // Pointer update; redirect wins over any push or pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (fq.Flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; contents are left untouched by reset and flush.
  always_ff @(posedge clk) begin
    if (push && !fq.Flush) begin
      mem[wr_ptr[AW-1:0]] <= '{PC: word_t'(fq.PushPC), Instr: word_t'(fq.PushInstr)};
    end
  end

  // Head read, forced to zero when nothing is queued.
  always_comb begin
    head = '0;
    if (!empty) head = mem[rd_ptr[AW-1:0]];
  end

  assign fq.PushReady  = ~full;
  assign fq.PopValid   = ~empty;
  assign fq.PopPC      = XLEN'(head.PC);
  assign fq.PopInstr   = XLEN'(head.Instr);
  assign fq.PopPCPlus4 = empty ? '0 : XLEN'(head.PC + word_t'(4));
  assign fq.Count      = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table plus scoreboard.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fetch_entry_t sb[$];

  fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) fq ();

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .fq  (fq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  fl;
    logic  pv;
    word_t pc;
    word_t ins;
    logic  pr;
    int    exp_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Compare all outputs against the scoreboard model.
  task automatic check_outputs();
    word_t epc;
    word_t eins;
    word_t ep4;
    epc  = '0;
    eins = '0;
    ep4  = '0;
    if (sb.size() > 0) begin
      epc  = sb[0].PC;
      eins = sb[0].Instr;
      ep4  = sb[0].PC + 32'd4;
    end
    chk("pop_valid",  {31'b0, fq.PopValid},  {31'b0, sb.size() > 0});
    chk("push_ready", {31'b0, fq.PushReady}, {31'b0, sb.size() < DEPTH});
    chk("count",      {29'b0, fq.Count},     32'(sb.size()));
    chk("pop_pc",     fq.PopPC,      epc);
    chk("pop_instr",  fq.PopInstr,   eins);
    chk("pop_pc4",    fq.PopPCPlus4, ep4);
  endtask

  // One cycle: drive after negedge, check, clock, update model.
  task automatic step(input logic fl, input logic pv, input word_t pc,
                      input word_t ins, input logic pr);
    bit acc_push;
    bit acc_pop;
    fq.Flush     = fl;
    fq.PushValid = pv;
    fq.PushPC    = pc;
    fq.PushInstr = ins;
    fq.PopReady  = pr;
    #1;
    check_outputs();
    acc_push = pv && (sb.size() < DEPTH);
    acc_pop  = pr && (sb.size() > 0);
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      if (acc_pop)  void'(sb.pop_front());
      if (acc_push) sb.push_back('{PC: pc, Instr: ins});
    end
    @(negedge clk);
    fq.Flush     = 1'b0;
    fq.PushValid = 1'b0;
    fq.PopReady  = 1'b0;
  endtask

  initial begin
    fq.Flush     = 1'b0;
    fq.PushValid = 1'b0;
    fq.PushPC    = '0;
    fq.PushInstr = '0;
    fq.PopReady  = 1'b0;

    // Fill, overfill, drain; flush with push/pop; PC+4 wrap.
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 0});
    vecs.push_back('{1'b0, 1'b1, 32'h00,       32'h00500093, 1'b0, 1});
    vecs.push_back('{1'b0, 1'b1, 32'h04,       32'h00600113, 1'b0, 2});
    vecs.push_back('{1'b0, 1'b1, 32'h08,       32'h00700193, 1'b0, 3});
    vecs.push_back('{1'b0, 1'b1, 32'h0C,       32'h00800213, 1'b0, 4});
    vecs.push_back('{1'b0, 1'b1, 32'h10,       32'h00900293, 1'b0, 4});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 3});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 2});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 0});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 0});
    vecs.push_back('{1'b0, 1'b1, 32'h20,       32'h11111111, 1'b0, 1});
    vecs.push_back('{1'b0, 1'b1, 32'h24,       32'h22222222, 1'b0, 2});
    vecs.push_back('{1'b0, 1'b1, 32'h28,       32'h33333333, 1'b0, 3});
    vecs.push_back('{1'b1, 1'b1, 32'h40,       32'h44444444, 1'b1, 0});
    vecs.push_back('{1'b0, 1'b1, 32'h80,       32'h88888888, 1'b0, 1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 0});
    vecs.push_back('{1'b0, 1'b1, 32'hFFFFFFFC, 32'h0000006F, 1'b0, 1});
    vecs.push_back('{1'b0, 1'b0, 32'h0,        32'h0,        1'b1, 0});

    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].fl, vecs[i].pv, vecs[i].pc, vecs[i].ins, vecs[i].pr);
      chk($sformatf("vec%0d_count", i), {29'b0, fq.Count}, 32'(vecs[i].exp_cnt));
    end

    // Sustained push+pop across the pointer wrap.
    step(1'b0, 1'b1, 32'h1000, 32'hA0000000, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 1'b1, 32'h1000 + 32'(i * 4), 32'hA0000000 + 32'(i), 1'b1);
      chk("stream_count", {29'b0, fq.Count}, 32'd1);
    end
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    chk("stream_drained", {29'b0, fq.Count}, 32'd0);

    // Asynchronous reset between edges with two entries queued.
    step(1'b0, 1'b1, 32'h200, 32'hB0000001, 1'b0);
    step(1'b0, 1'b1, 32'h204, 32'hB0000002, 1'b0);
    chk("pre_rst_count", {29'b0, fq.Count}, 32'd2);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    chk("async_rst_valid", {31'b0, fq.PopValid}, 32'd0);
    chk("async_rst_count", {29'b0, fq.Count},    32'd0);
    chk("async_rst_pc",    fq.PopPC,             32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b1, 32'h300, 32'hC0000003, 1'b0);
    chk("post_rst_count", {29'b0, fq.Count}, 32'd1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
